// File: rtl/aes_round_pipe_reg.sv
// Elastic pipeline register for AES round state, round key and round tag.
// DEPTH stages with valid/ready backpressure, synchronous reset, flush and
// registered occupancy. Define AES_ROUND_ZEROIZE_EN to make flush also clear
// every stage's payload registers.
module aes_round_pipe_reg #(
    parameter int unsigned DATA_W = 128,
    parameter int unsigned KEY_W  = 128,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned DEPTH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          r_in,
    input  logic [KEY_W-1:0]           key_in,
    input  logic [TAG_W-1:0]           tag_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          r_out,
    output logic [KEY_W-1:0]           key_out,
    output logic [TAG_W-1:0]           tag_out,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int unsigned OccW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]  v_q, v_d, free;
    logic [DATA_W-1:0] r_q   [DEPTH];
    logic [DATA_W-1:0] r_d   [DEPTH];
    logic [KEY_W-1:0]  key_q [DEPTH];
    logic [KEY_W-1:0]  key_d [DEPTH];
    logic [TAG_W-1:0]  tag_q [DEPTH];
    logic [TAG_W-1:0]  tag_d [DEPTH];
    logic [OccW-1:0]   occ_q, occ_d;

    // Ready chain: a stage is free if empty or its successor can move on.
    always_comb begin
        free = '0;
        free[DEPTH-1] = !v_q[DEPTH-1] || out_ready;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            free[i] = !v_q[i] || free[i+1];
        end
    end

    assign in_ready = free[0] && !flush && !rst;

    // Next-state: shift into free stages, clear valids on flush, count occupancy.
    always_comb begin
        v_d   = v_q;
        r_d   = r_q;
        key_d = key_q;
        tag_d = tag_q;
        if (flush) begin
            v_d = '0;
`ifdef AES_ROUND_ZEROIZE_EN
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_d[i]   = '0;
                key_d[i] = '0;
                tag_d[i] = '0;
            end
`endif
        end else begin
            if (free[0]) begin
                v_d[0] = in_valid;
                // Payload only loads behind a real beat so bubbles keep stale data quiet.
                if (in_valid) begin
                    r_d[0]   = r_in;
                    key_d[0] = key_in;
                    tag_d[0] = tag_in;
                end
            end
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (free[i]) begin
                    v_d[i] = v_q[i-1];
                    if (v_q[i-1]) begin
                        r_d[i]   = r_q[i-1];
                        key_d[i] = key_q[i-1];
                        tag_d[i] = tag_q[i-1];
                    end
                end
            end
        end
        occ_d = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            occ_d = occ_d + OccW'(v_d[i]);
        end
    end

    // Stage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q   <= '0;
            occ_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_q[i]   <= '0;
                key_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else begin
            v_q   <= v_d;
            occ_q <= occ_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_q[i]   <= r_d[i];
                key_q[i] <= key_d[i];
                tag_q[i] <= tag_d[i];
            end
        end
    end

    assign out_valid = v_q[DEPTH-1];
    assign r_out     = r_q[DEPTH-1];
    assign key_out   = key_q[DEPTH-1];
    assign tag_out   = tag_q[DEPTH-1];
    assign occupancy = occ_q;

endmodule

// File: tb/tb_aes_round_pipe_reg.sv
// Directed bench for aes_round_pipe_reg at DEPTH=2.
module tb_aes_round_pipe_reg;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [127:0] r_in, key_in, r_out, key_out;
    logic [3:0]   tag_in, tag_out;
    logic [1:0]   occupancy;

    int total = 0;
    int bad   = 0;
    logic [127:0] r_hold;

    aes_round_pipe_reg #(
        .DATA_W(128), .KEY_W(128), .TAG_W(4), .DEPTH(2)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .r_in(r_in), .key_in(key_in), .tag_in(tag_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .r_out(r_out), .key_out(key_out), .tag_out(tag_out),
        .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Beat payload derived from its tag so any beat is recognisable at the output.
    task automatic drive(input logic v, input logic [3:0] t);
        in_valid = v;
        tag_in   = t;
        key_in   = {32{t}};
        r_in     = ~{32{t}};
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        drive(1'b1, 4'd0);
        #1;
        chk("rst_in_ready", in_ready, 0);
        tick; tick;
        chk("rst_in_ready2", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_r_out", r_out, 0);
        chk("rst_key_out", key_out, 0);
        chk("rst_tag_out", tag_out, 0);

        // Reset then stream: two beats, latency DEPTH.
        rst = 1'b0;
        in_valid = 1'b1;
        r_in   = 128'h00112233445566778899aabbccddeeff;
        key_in = 128'h000102030405060708090a0b0c0d0e0f;
        tag_in = 4'd1;
        #1;
        chk("s1_in_ready", in_ready, 1);
        tick;
        chk("s1_occ1", occupancy, 1);
        chk("s1_ov0", out_valid, 0);
        drive(1'b1, 4'd2);
        tick;
        chk("s1_occ2", occupancy, 2);
        chk("s1_ov1", out_valid, 1);
        chk("s1_r", r_out, 128'h00112233445566778899aabbccddeeff);
        chk("s1_key", key_out, 128'h000102030405060708090a0b0c0d0e0f);
        chk("s1_tag", tag_out, 1);
        drive(1'b0, 4'd0);
        tick;
        chk("s1_occ_b", occupancy, 1);
        chk("s1_tag2", tag_out, 2);
        chk("s1_key2", key_out, {32{4'd2}});
        tick;
        chk("s1_occ_c", occupancy, 0);
        chk("s1_ov_end", out_valid, 0);

        // Back-to-back: tags 0..9 with out_ready held high.
        for (int j = 0; j < 12; j++) begin
            if (j < 10) begin
                drive(1'b1, 4'(j));
                #1;
                chk("b2b_in_ready", in_ready, 1);
            end else begin
                drive(1'b0, 4'd0);
            end
            tick;
            chk("b2b_ov", out_valid, (j >= 1 && j <= 10) ? 1 : 0);
            if (j >= 1 && j <= 10) chk("b2b_tag", tag_out, 128'(j - 1));
        end

        // Backpressure: fill with tags 3,4 and hold.
        out_ready = 1'b0;
        drive(1'b1, 4'd3);
        tick;
        drive(1'b1, 4'd4);
        tick;
        drive(1'b1, 4'd5);
        #1;
        chk("bp_in_ready", in_ready, 0);
        chk("bp_occ", occupancy, 2);
        r_hold = r_out;
        chk("bp_r_first", r_hold, ~{32{4'd3}});
        for (int k = 0; k < 5; k++) begin
            tick;
            chk("bp_r_stable", r_out, r_hold);
            chk("bp_tag_stable", tag_out, 3);
            chk("bp_occ_hold", occupancy, 2);
        end
        drive(1'b0, 4'd0);
        out_ready = 1'b1;
        tick;
        chk("bp_ov4", out_valid, 1);
        chk("bp_tag4", tag_out, 4);
        chk("bp_occ1", occupancy, 1);
        tick;
        chk("bp_ov_end", out_valid, 0);
        chk("bp_occ0", occupancy, 0);

        // Full pipe with simultaneous exchange.
        out_ready = 1'b0;
        drive(1'b1, 4'd5);
        tick;
        drive(1'b1, 4'd6);
        tick;
        chk("fx_tag5", tag_out, 5);
        out_ready = 1'b1;
        drive(1'b1, 4'd7);
        #1;
        chk("fx_in_ready", in_ready, 1);
        tick;
        drive(1'b0, 4'd0);
        chk("fx_tag6", tag_out, 6);
        chk("fx_occ2", occupancy, 2);
        tick;
        chk("fx_tag7", tag_out, 7);
        chk("fx_occ1", occupancy, 1);
        tick;
        chk("fx_occ0", occupancy, 0);

        // Flush with a beat presented.
        out_ready = 1'b0;
        drive(1'b1, 4'd8);
        tick;
        drive(1'b1, 4'd9);
        tick;
        chk("fl_occ2", occupancy, 2);
        chk("fl_key8", key_out, {32{4'd8}});
        flush = 1'b1;
        drive(1'b1, 4'hA);
        #1;
        chk("fl_in_ready", in_ready, 0);
        tick;
        flush = 1'b0;
        drive(1'b0, 4'd0);
        out_ready = 1'b1;
        chk("fl_occ0", occupancy, 0);
        chk("fl_ov0", out_valid, 0);
`ifdef AES_ROUND_ZEROIZE_EN
        chk("fl_key_zero", key_out, 0);
`else
        chk("fl_key_hold", key_out, {32{4'd8}});
`endif
        tick;
        chk("fl_not_accepted_ov", out_valid, 0);
        chk("fl_not_accepted_occ", occupancy, 0);

        // Mid-stream reset while full and stalled.
        out_ready = 1'b0;
        drive(1'b1, 4'd1);
        tick;
        drive(1'b1, 4'd2);
        tick;
        chk("mr_occ2", occupancy, 2);
        rst = 1'b1;
        #1;
        chk("mr_in_ready", in_ready, 0);
        tick;
        chk("mr_ov", out_valid, 0);
        chk("mr_occ", occupancy, 0);
        chk("mr_r", r_out, 0);
        chk("mr_key", key_out, 0);
        chk("mr_tag", tag_out, 0);
        rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 4'd5);
        #1;
        chk("mr_resume_ready", in_ready, 1);
        tick;
        drive(1'b0, 4'd0);
        chk("mr_resume_occ", occupancy, 1);
        tick;
        chk("mr_resume_ov", out_valid, 1);
        chk("mr_resume_tag", tag_out, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
